// File: rtl/yarp_mem_responder_if.sv
// Request/response bundle between a memory initiator and
// yarp_mem_responder.
interface yarp_mem_responder_if #(
    parameter int XLEN = 32
);
    logic              mem_req_i;
    logic [XLEN-1:0]   mem_addr_i;
    logic              mem_wr_i;
    logic [XLEN/8-1:0] mem_byte_en_i;
    logic [XLEN-1:0]   mem_wr_data_i;
    logic              mem_gnt_o;
    logic              mem_rvalid_o;
    logic [XLEN-1:0]   mem_rd_data_o;
    logic              mem_err_o;

    modport master (
        output mem_req_i,
        output mem_addr_i,
        output mem_wr_i,
        output mem_byte_en_i,
        output mem_wr_data_i,
        input  mem_gnt_o,
        input  mem_rvalid_o,
        input  mem_rd_data_o,
        input  mem_err_o
    );

    modport slave (
        input  mem_req_i,
        input  mem_addr_i,
        input  mem_wr_i,
        input  mem_byte_en_i,
        input  mem_wr_data_i,
        output mem_gnt_o,
        output mem_rvalid_o,
        output mem_rd_data_o,
        output mem_err_o
    );
endinterface

// File: rtl/yarp_mem_responder.sv
// Single-port word memory: one response per granted request after
// RD_LATENCY cycles; misaligned or out-of-window requests fault.
module yarp_mem_responder #(
    parameter int          XLEN        = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          RD_LATENCY  = 1
) (
    input logic               clk,
    input logic               reset,
    yarp_mem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int NB = XLEN / 8;
    localparam logic [XLEN-1:0] LIMIT = XLEN'(DEPTH_WORDS * 4);
    localparam logic [2:0] CNT_INIT =
        3'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

    if (XLEN != 32) begin : g_bad_xlen
        $error("yarp_mem_responder: XLEN must be 32");
    end
    if (DEPTH_WORDS < 2 ||
        (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("yarp_mem_responder: DEPTH_WORDS must be a power of two");
    end
    if ((BASE_ADDR & (LIMIT - 1)) != 0) begin : g_bad_base
        $error("yarp_mem_responder: BASE_ADDR not aligned to window");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_lat
        $error("yarp_mem_responder: RD_LATENCY must be 1..8");
    end

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    logic [2:0]      cnt;
    logic            gnt_q;
    logic            rvalid_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;
    logic [XLEN-1:0] pend_data;
    logic            pend_err;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic [XLEN-1:0] offset;
    logic [AW-1:0]   idx;
    logic            misaligned;
    logic            out_of_range;
    logic            fault;
    logic            accept;
    logic            wr_commit;
    logic [XLEN-1:0] resp_data;

    // Offset wraps, so addresses below BASE_ADDR land out of range.
    assign offset       = bus.mem_addr_i - BASE_ADDR;
    assign idx          = offset[AW+1:2];
    assign misaligned   = |bus.mem_addr_i[1:0];
    assign out_of_range = offset >= LIMIT;
    assign fault        = misaligned | out_of_range;
    assign accept       = bus.mem_req_i & gnt_q;
    assign wr_commit    = accept & bus.mem_wr_i & ~fault;
    assign resp_data    = (bus.mem_wr_i | fault) ? '0 : mem[idx];

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.mem_byte_en_i[b]) begin
                    mem[idx][8*b +: 8] <= bus.mem_wr_data_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            cnt       <= '0;
            gnt_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            pend_data <= '0;
            pend_err  <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            unique case (state)
                INIT: begin
                    state <= IDLE;
                    gnt_q <= 1'b1;
                end
                IDLE, RESP: begin
                    if (accept && RD_LATENCY == 1) begin
                        state    <= RESP;
                        gnt_q    <= 1'b1;
                        rvalid_q <= 1'b1;
                        rdata_q  <= resp_data;
                        err_q    <= fault;
                    end else if (accept) begin
                        state     <= WAIT;
                        gnt_q     <= 1'b0;
                        cnt       <= CNT_INIT;
                        pend_data <= resp_data;
                        pend_err  <= fault;
                    end else begin
                        state <= IDLE;
                        gnt_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state    <= RESP;
                        gnt_q    <= 1'b1;
                        rvalid_q <= 1'b1;
                        rdata_q  <= pend_data;
                        err_q    <= pend_err;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= INIT;
                    gnt_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_gnt_o     = gnt_q;
    assign bus.mem_rvalid_o  = rvalid_q;
    assign bus.mem_rd_data_o = rdata_q;
    assign bus.mem_err_o     = err_q;

endmodule
